quick_spi_cmd_sequencer: RTL and testbench
==========================================

// Module: quick_spi_cmd_sequencer
// PURPOSE
//  Upstream command stage for quick_spi: buffers SPI transactions in a small FIFO and
//  drives quick_spi's enable/operation/slave/outgoing_data one transaction at a time.
//  Tracks quick_spi busy, captures incoming_data on completion and returns one in-order
//  response per command. Lets a host or bus bridge queue transfers without polling busy.
// PARAMETERS
//  DEPTH           4    command FIFO entries; power of two, >= 2
//  SLAVE_W         2    width of slave select index (matches quick_spi slave port)
//  TIMEOUT_CYCLES  1024 watchdog limit in clk cycles; used only with the timeout macro
// PORTS
//  clk                input   1        system clock, all logic on rising edge
//  reset_n            input   1        asynchronous active-low reset
//  cmd_valid          input   1        command offered
//  cmd_ready          output  1        FIFO not full (= !full)
//  cmd_op             input   1        1 = write, 0 = read
//  cmd_slave          input   SLAVE_W  target slave index
//  cmd_data           input   16       outgoing payload
//  rsp_valid          output  1        response held for host
//  rsp_ready          input   1        host accepts response
//  rsp_data           output  8        captured incoming_data (0 for writes/errors)
//  rsp_err            output  1        transaction timed out
//  spi_enable         output  1        to quick_spi enable
//  spi_operation      output  1        to quick_spi operation
//  spi_slave          output  SLAVE_W  to quick_spi slave
//  spi_outgoing_data  output  16       to quick_spi outgoing_data
//  spi_busy           input   1        from quick_spi busy
//  spi_incoming_data  input   8        from quick_spi incoming_data
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; spi_enable/spi_operation/rsp_valid/rsp_err = 0,
//   spi_slave/spi_outgoing_data/rsp_data = 0; cmd_ready = 1 after release.
//  FIFO: push on cmd_valid&&cmd_ready; pop only in IDLE; push+pop same cycle allowed
//   when full (pop frees slot next cycle, cmd_ready stays combinational on full).
//   Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
//  FSM (all outputs registered):
//   IDLE   : !empty && !rsp_valid -> pop head into spi_* regs, go LAUNCH.
//   LAUNCH : spi_enable=1; on spi_busy==1 sampled -> spi_enable=0, go WAIT.
//   WAIT   : on spi_busy==0 -> rsp_data = op ? 0 : spi_incoming_data, rsp_valid=1, go RESP.
//   RESP   : hold rsp_* stable until rsp_valid&&rsp_ready, then rsp_valid=0, go IDLE.
//  Latency: cmd accepted at edge N into empty FIFO while idle -> spi_enable high after
//   edge N+2 (pop at N+1); response valid 1 cycle after busy falls.
//  spi_slave/spi_operation/spi_outgoing_data held constant from LAUNCH through RESP.
//  Only one transaction in flight; next launch waits for response handshake.
//  Reset mid-operation: immediate return to reset values; queued commands discarded.
//  spi_busy high while IDLE is ignored (no launch blocked, no response generated).
// CONFIGURATION
//  QUICK_SPI_SEQ_TIMEOUT_EN defined: counter cleared on entering LAUNCH, counts in
//   LAUNCH+WAIT; at TIMEOUT_CYCLES -> spi_enable=0, rsp_err=1, rsp_data=0, go RESP.
//   rsp_err clears with rsp handshake.
//  Not defined: no counter; rsp_err tied 0; FSM waits on spi_busy indefinitely.
// TESTING (bench drives real quick_spi plus a busy-stub mode)
//  1 write op=1 slave=1 data=16'h5A5A -> spi_operation=1, spi_slave=1,
//    spi_outgoing_data=5A5A, spi_enable until busy; rsp_data=0, rsp_err=0.
//  2 read op=0, stub busy 20 cycles, incoming=8'hC3 -> rsp_valid 1 cycle after busy
//    falls, rsp_data=C3.
//  3 rsp_ready=0, push 6 cmds (DEPTH=4) -> 5 accepted, 6th sees cmd_ready=0;
//    release -> 5 responses in order, data matches each command.
//  4 rsp_ready held 0 for 50 cycles after first response -> no spi_enable, rsp_* stable.
//  5 macro on, TIMEOUT_CYCLES=64, busy stuck 0 -> rsp_err=1 after 64 cycles, enable 0;
//    macro off -> still LAUNCH, spi_enable=1 after 200 cycles.
//  6 reset_n low during WAIT with 2 queued -> outputs at reset values, cmd_ready=1,
//    no response after release.

Source files
------------

// File: rtl/quick_spi_cmd_sequencer_if.sv
// Command/response/quick_spi signal bundle for the quick_spi command sequencer.
// master = host + quick_spi side, slave = sequencer side.
interface quick_spi_cmd_sequencer_if #(
  parameter int unsigned SLAVE_W = 2
);
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RSP_W  = 8;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_op;
  logic [SLAVE_W-1:0]  cmd_slave;
  logic [DATA_W-1:0]   cmd_data;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RSP_W-1:0]    rsp_data;
  logic                rsp_err;

  logic                spi_enable;
  logic                spi_operation;
  logic [SLAVE_W-1:0]  spi_slave;
  logic [DATA_W-1:0]   spi_outgoing_data;
  logic                spi_busy;
  logic [RSP_W-1:0]    spi_incoming_data;

  modport master (
    output cmd_valid, cmd_op, cmd_slave, cmd_data, rsp_ready, spi_busy, spi_incoming_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err,
           spi_enable, spi_operation, spi_slave, spi_outgoing_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_slave, cmd_data, rsp_ready, spi_busy, spi_incoming_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err,
           spi_enable, spi_operation, spi_slave, spi_outgoing_data
  );
endinterface

// File: rtl/quick_spi_cmd_sequencer.sv
// Queues SPI commands in a FIFO and runs them through quick_spi one at a time,
// returning one in-order response each. Optional watchdog: QUICK_SPI_SEQ_TIMEOUT_EN.
module quick_spi_cmd_sequencer #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned SLAVE_W        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset_n,
  quick_spi_cmd_sequencer_if.slave    bus
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned RSP_W  = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("quick_spi_cmd_sequencer: DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  logic                r_op_mem    [DEPTH];
  logic [SLAVE_W-1:0]  r_slave_mem [DEPTH];
  logic [DATA_W-1:0]   r_data_mem  [DEPTH];
  logic [AW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic                w_full, w_empty, w_push, w_pop;

  logic [1:0]          r_state, w_state_nxt;
  logic                r_spi_enable, w_spi_enable_nxt;
  logic                r_spi_op, w_spi_op_nxt;
  logic [SLAVE_W-1:0]  r_spi_slave, w_spi_slave_nxt;
  logic [DATA_W-1:0]   r_spi_data, w_spi_data_nxt;
  logic                r_rsp_valid, w_rsp_valid_nxt;
  logic [RSP_W-1:0]    r_rsp_data, w_rsp_data_nxt;

`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       r_tmo_cnt, w_tmo_cnt_nxt;
  logic                r_rsp_err, w_rsp_err_nxt;
`endif

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.cmd_valid && !w_full;

  // FIFO storage (no reset needed, guarded by count)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op_mem[r_wr_ptr]    <= bus.cmd_op;
      r_slave_mem[r_wr_ptr] <= bus.cmd_slave;
      r_data_mem[r_wr_ptr]  <= bus.cmd_data;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt      = r_state;
    w_pop            = 1'b0;
    w_spi_enable_nxt = r_spi_enable;
    w_spi_op_nxt     = r_spi_op;
    w_spi_slave_nxt  = r_spi_slave;
    w_spi_data_nxt   = r_spi_data;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_data_nxt   = r_rsp_data;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_rsp_err_nxt    = r_rsp_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !r_rsp_valid) begin
          w_pop           = 1'b1;
          w_spi_op_nxt    = r_op_mem[r_rd_ptr];
          w_spi_slave_nxt = r_slave_mem[r_rd_ptr];
          w_spi_data_nxt  = r_data_mem[r_rd_ptr];
          w_state_nxt     = S_LAUNCH;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
          w_tmo_cnt_nxt   = '0;
`endif
        end
      end
      S_LAUNCH: begin
        // busy only counts once enable has actually been presented
        w_spi_enable_nxt = 1'b1;
        if (r_spi_enable && bus.spi_busy) begin
          w_spi_enable_nxt = 1'b0;
          w_state_nxt      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!bus.spi_busy) begin
          w_rsp_data_nxt  = r_spi_op ? '0 : bus.spi_incoming_data;
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
          w_rsp_err_nxt   = 1'b0;
`endif
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    if (r_state == S_LAUNCH || r_state == S_WAIT) begin
      if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        w_spi_enable_nxt = 1'b0;
        w_rsp_err_nxt    = 1'b1;
        w_rsp_data_nxt   = '0;
        w_rsp_valid_nxt  = 1'b1;
        w_state_nxt      = S_RESP;
      end else begin
        w_tmo_cnt_nxt    = r_tmo_cnt + TW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_spi_enable <= 1'b0;
      r_spi_op     <= 1'b0;
      r_spi_slave  <= '0;
      r_spi_data   <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
      r_tmo_cnt    <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_spi_enable <= w_spi_enable_nxt;
      r_spi_op     <= w_spi_op_nxt;
      r_spi_slave  <= w_spi_slave_nxt;
      r_spi_data   <= w_spi_data_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
`endif
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.cmd_ready         = !w_full;
  assign bus.spi_enable        = r_spi_enable;
  assign bus.spi_operation     = r_spi_op;
  assign bus.spi_slave         = r_spi_slave;
  assign bus.spi_outgoing_data = r_spi_data;
  assign bus.rsp_valid         = r_rsp_valid;
  assign bus.rsp_data          = r_rsp_data;
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
  assign bus.rsp_err           = r_rsp_err;
`else
  assign bus.rsp_err           = 1'b0;
`endif

endmodule

// File: tb/tb_quick_spi_cmd_sequencer.sv
// Bench for quick_spi_cmd_sequencer: directed latency/reset cases plus randomized traffic
// against a busy stub and an in-order command/response model.
module tb_quick_spi_cmd_sequencer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned SLAVE_W = 2;
  localparam int unsigned TMO     = 64;

  typedef struct packed {
    logic        op;
    logic [1:0]  slave;
    logic [15:0] data;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  quick_spi_cmd_sequencer_if #(.SLAVE_W(SLAVE_W)) bus ();

  quick_spi_cmd_sequencer #(
    .DEPTH(DEPTH), .SLAVE_W(SLAVE_W), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rsp   = 0;
  bit   stub_en = 0;
  bit   cons_en = 0;
  cmd_t cmd_q[$];
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic op, input logic [1:0] sl, input logic [15:0] d,
                      input bit track, output bit acc);
    cmd_t c;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_slave = sl;
    bus.cmd_data  = d;
    acc = bus.cmd_ready;
    c.op = op; c.slave = sl; c.data = d;
    if (track && acc) cmd_q.push_back(c);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int k = 0;
    while (!bus.spi_enable && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.spi_enable), 1);
  endtask

  // Busy stub: answers each launch after a random delay/length with random data
  initial begin : stub
    cmd_t c;
    bit   have;
    logic [7:0] din;
    forever begin
      @(negedge clk);
      if (stub_en && bus.spi_enable && !bus.spi_busy) begin
        have = (cmd_q.size() != 0);
        if (!have) check("launch_unexpected", 1, 0);
        else begin
          c = cmd_q.pop_front();
          check("launch_op", 32'(bus.spi_operation), 32'(c.op));
          check("launch_slave", 32'(bus.spi_slave), 32'(c.slave));
          check("launch_data", 32'(bus.spi_outgoing_data), 32'(c.data));
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.spi_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk);
        din = 8'($urandom);
        bus.spi_incoming_data = din;
        bus.spi_busy = 1'b0;
        if (have) exp_q.push_back(c.op ? 8'h00 : din);
      end
    end
  end

  // Response consumer with random backpressure
  initial begin : cons
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (cons_en) begin
        bus.rsp_ready = ($urandom_range(0, 3) != 0);
        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rsp_data", 32'(bus.rsp_data), 32'(e));
            check("rsp_err", 32'(bus.rsp_err), 0);
          end
          n_rsp++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit acc;
    int n_acc;
    int target;
    int k;
    int seen_en, seen_rsp;
    bit last_acc;

    bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_slave = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b0; bus.spi_busy = 1'b0; bus.spi_incoming_data = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_en", 32'(bus.spi_enable), 0);
    check("rst_op", 32'(bus.spi_operation), 0);
    check("rst_slave", 32'(bus.spi_slave), 0);
    check("rst_out", 32'(bus.spi_outgoing_data), 0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_rsp_data", 32'(bus.rsp_data), 0);
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);

    // Write: launch latency and zero response data
    bus.spi_incoming_data = 8'hFF;
    push(1'b1, 2'd1, 16'h5A5A, 0, acc);
    check("t1_accept", 32'(acc), 1);
    @(negedge clk);
    check("t1_en_n0", 32'(bus.spi_enable), 0);
    @(negedge clk);
    check("t1_en_n1", 32'(bus.spi_enable), 0);
    check("t1_op", 32'(bus.spi_operation), 1);
    check("t1_slave", 32'(bus.spi_slave), 1);
    check("t1_out", 32'(bus.spi_outgoing_data), 32'h5A5A);
    @(negedge clk);
    check("t1_en_n2", 32'(bus.spi_enable), 1);
    bus.spi_busy = 1'b1;
    @(negedge clk);
    check("t1_en_drop", 32'(bus.spi_enable), 0);
    repeat (2) @(negedge clk);
    bus.spi_busy = 1'b0;
    check("t1_rsp_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    check("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t1_rsp_data", 32'(bus.rsp_data), 0);
    check("t1_rsp_err", 32'(bus.rsp_err), 0);
    check("t1_hold_out", 32'(bus.spi_outgoing_data), 32'h5A5A);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("t1_rsp_done", 32'(bus.rsp_valid), 0);

    // Read with 20-cycle busy
    push(1'b0, 2'd2, 16'h1234, 0, acc);
    wait_en("t2_launch");
    bus.spi_busy = 1'b1;
    bus.spi_incoming_data = 8'hC3;
    repeat (20) @(negedge clk);
    check("t2_en_low", 32'(bus.spi_enable), 0);
    check("t2_slave", 32'(bus.spi_slave), 2);
    bus.spi_busy = 1'b0;
    check("t2_rsp_early", 32'(bus.rsp_valid), 0);
    @(negedge clk);
    check("t2_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t2_rsp_data", 32'(bus.rsp_data), 32'hC3);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Overfill with no host acceptance: 5 accepted, 6th refused
    @(posedge clk); #1 stub_en = 1;
    n_acc = 0;
    last_acc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(1'($urandom), 2'($urandom), 16'($urandom), 1, acc);
      if (acc) n_acc++;
      last_acc = acc;
    end
    check("t3_accepted", 32'(n_acc), 5);
    check("t3_sixth_ready", 32'(last_acc), 0);
    k = 0;
    while (!bus.rsp_valid && k < 100) begin @(negedge clk); k++; end
    check("t3_first_rsp", 32'(bus.rsp_valid), 1);

    // Response stall: nothing launches, response held
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("t4_en_stall", 32'(bus.spi_enable), 0);
      check("t4_rsp_hold", 32'({bus.rsp_valid, bus.rsp_data}), 32'({1'b1, exp_q[0]}));
    end
    @(posedge clk); #1 cons_en = 1;
    k = 0;
    while (n_rsp < 5 && k < 500) begin @(negedge clk); k++; end
    check("t3_rsp_count", 32'(n_rsp), 5);

    // Randomized traffic
    target = n_rsp;
    for (int i = 0; i < 40; i++) begin
      k = 0;
      do begin
        push(1'($urandom), 2'($urandom), 16'($urandom), 1, acc);
        k++;
      end while (!acc && k < 200);
      if (acc) target++;
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    k = 0;
    while (n_rsp < target && k < 5000) begin @(negedge clk); k++; end
    check("rand_rsp_count", 32'(n_rsp), 32'(target));
    check("rand_cmd_left", 32'(cmd_q.size()), 0);
    check("rand_exp_left", 32'(exp_q.size()), 0);
    @(posedge clk); #1;
    cons_en = 0;
    stub_en = 0;
    bus.rsp_ready = 1'b0;

    // Busy never asserts
    push(1'b1, 2'd3, 16'hBEEF, 0, acc);
`ifdef QUICK_SPI_SEQ_TIMEOUT_EN
    k = 0;
    while (!bus.rsp_valid && k < 200) begin @(negedge clk); k++; end
    check("t5_tmo_rsp", 32'(bus.rsp_valid), 1);
    check("t5_tmo_err", 32'(bus.rsp_err), 1);
    check("t5_tmo_data", 32'(bus.rsp_data), 0);
    check("t5_tmo_en", 32'(bus.spi_enable), 0);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("t5_err_clear", 32'(bus.rsp_err), 0);
`else
    repeat (200) @(negedge clk);
    check("t5_still_en", 32'(bus.spi_enable), 1);
    check("t5_no_rsp", 32'(bus.rsp_valid), 0);
`endif
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;

    // Reset during WAIT with two commands queued
    for (int i = 0; i < 3; i++) push(1'b0, 2'(i), 16'(i + 16'h100), 0, acc);
    wait_en("t6_launch");
    bus.spi_busy = 1'b1;
    repeat (2) @(negedge clk);
    check("t6_in_wait", 32'(bus.spi_enable), 0);
    reset_n = 1'b0;
    #1;
    check("t6_rst_op", 32'(bus.spi_operation), 0);
    check("t6_rst_slave", 32'(bus.spi_slave), 0);
    check("t6_rst_out", 32'(bus.spi_outgoing_data), 0);
    check("t6_rst_rsp", 32'(bus.rsp_valid), 0);
    check("t6_rst_ready", 32'(bus.cmd_ready), 1);
    bus.spi_busy = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    seen_en = 0;
    seen_rsp = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.spi_enable) seen_en++;
      if (bus.rsp_valid) seen_rsp++;
    end
    check("t6_no_launch", 32'(seen_en), 0);
    check("t6_no_rsp", 32'(seen_rsp), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
